// File: rtl/kfmmc_data_line_if.sv
// Sequencer/pad bundle for the KFMMC DAT0 bit engine.
// master = sequencer + pad side, slave = data line engine.
interface kfmmc_data_line_if;
  logic        mmc_sample_edge;
  logic        mmc_shift_edge;
  logic        start_communication;
  logic        data_io;
  logic        check_data_start_bit;
  logic        read_continuous_data;
  logic        clear_data_crc;
  logic        clear_data_interrupt;
  logic        mask_data_interrupt;
  logic        set_send_data;
  logic [7:0]  send_data;
  logic [7:0]  received_data;
  logic        mmc_is_in_connecting;
  logic        sent_data_interrupt;
  logic        received_data_interrupt;
  logic        start_bit_timeout;
  logic [15:0] data_crc16;
  logic        mmc_data_out;
  logic        mmc_data_oe;
  logic        mmc_data_in;

  modport master (
    output mmc_sample_edge, mmc_shift_edge,
    output start_communication, data_io,
    output check_data_start_bit,
    output read_continuous_data,
    output clear_data_crc, clear_data_interrupt,
    output mask_data_interrupt, set_send_data,
    output send_data, mmc_data_in,
    input  received_data, mmc_is_in_connecting,
    input  sent_data_interrupt,
    input  received_data_interrupt,
    input  start_bit_timeout, data_crc16,
    input  mmc_data_out, mmc_data_oe
  );

  modport slave (
    input  mmc_sample_edge, mmc_shift_edge,
    input  start_communication, data_io,
    input  check_data_start_bit,
    input  read_continuous_data,
    input  clear_data_crc, clear_data_interrupt,
    input  mask_data_interrupt, set_send_data,
    input  send_data, mmc_data_in,
    output received_data, mmc_is_in_connecting,
    output sent_data_interrupt,
    output received_data_interrupt,
    output start_bit_timeout, data_crc16,
    output mmc_data_out, mmc_data_oe
  );
endinterface

// File: rtl/kfmmc_data_line.sv
// KFMMC DAT0 bit engine: one-byte serialise/deserialise with CRC16.
// Optional CRC16 logic built when KFMMC_DATA_CRC16_EN is defined.
module kfmmc_data_line #(
  parameter logic [15:0] START_TIMEOUT = 16'hFFFF
) (
  input logic              clock,
  input logic              reset,
  kfmmc_data_line_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_START, RECV
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_tx;
  logic [6:0]  r_rx;
  logic [7:0]  r_rx_data;
  logic [2:0]  r_cnt;
  logic [15:0] r_tmo;
  logic        r_out;
  logic        r_oe;
  logic        r_sent;
  logic        r_recv;
  logic        r_tmo_flag;

  logic w_start;
  logic w_smp;
  logic w_crc_en;
  logic w_crc_bit;
  logic w_send_done;
  logic w_recv_done;
  logic w_timeout;

  assign w_start = bus.start_communication
                 && (r_state == IDLE);
  assign w_smp   = bus.mmc_sample_edge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_crc_en    = 1'b0;
    w_crc_bit   = r_out;
    w_send_done = 1'b0;
    w_recv_done = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          if (!bus.data_io)
            w_next = SEND;
          else if (bus.check_data_start_bit)
            w_next = WAIT_START;
          else if (bus.read_continuous_data)
            w_next = RECV;
        end
      end
      SEND: begin
        // samples only count once a bit is on the pad
        if (w_smp && r_oe) begin
          w_crc_en = 1'b1;
          if (r_cnt == 3'd7) begin
            w_send_done = 1'b1;
            w_next      = IDLE;
          end
        end
      end
      WAIT_START: begin
        if (w_smp) begin
          if (!bus.mmc_data_in) begin
            w_next = RECV;
          end else if (r_tmo == START_TIMEOUT - 16'd1) begin
            w_timeout = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      RECV: begin
        if (w_smp) begin
          w_crc_en  = 1'b1;
          w_crc_bit = bus.mmc_data_in;
          if (r_cnt == 3'd7) begin
            w_recv_done = 1'b1;
            w_next      = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx       <= 8'h00;
      r_rx       <= 7'h00;
      r_rx_data  <= 8'h00;
      r_cnt      <= 3'd0;
      r_tmo      <= 16'h0000;
      r_out      <= 1'b1;
      r_oe       <= 1'b0;
      r_tmo_flag <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt <= 3'd0;
        r_tmo <= 16'h0000;
        if (bus.set_send_data)
          r_tx <= bus.send_data;
      end
      if (r_state == SEND) begin
        if (w_smp && r_oe)
          r_cnt <= r_cnt + 3'd1;
        // sample of the same cycle is handled before the shift
        if (w_send_done) begin
          r_oe  <= 1'b0;
          r_out <= 1'b1;
        end else if (bus.mmc_shift_edge) begin
          r_out <= r_tx[7];
          r_tx  <= {r_tx[6:0], 1'b0};
          r_oe  <= 1'b1;
        end
      end
      if (r_state == WAIT_START && w_smp)
        r_tmo <= r_tmo + 16'd1;
      if (r_state == RECV && w_smp) begin
        r_rx  <= {r_rx[5:0], bus.mmc_data_in};
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_recv_done) begin
        r_rx_data  <= {r_rx, bus.mmc_data_in};
        r_tmo_flag <= 1'b0;
      end
      if (w_timeout) begin
        r_rx_data  <= 8'hFF;
        r_tmo_flag <= 1'b1;
      end
    end
  end

  // a completion in the same cycle as a clear keeps the flag set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sent <= 1'b0;
      r_recv <= 1'b0;
    end else begin
      r_sent <= w_send_done
             | (r_sent & ~bus.clear_data_interrupt);
      r_recv <= w_recv_done | w_timeout
             | (r_recv & ~bus.clear_data_interrupt);
    end
  end

`ifdef KFMMC_DATA_CRC16_EN
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ w_crc_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_crc <= 16'h0000;
    else if (w_start && bus.clear_data_crc)
      r_crc <= 16'h0000;
    else if (w_crc_en)
      r_crc <= {r_crc[14:0], 1'b0}
             ^ (w_fb ? 16'h1021 : 16'h0000);
  end

  assign bus.data_crc16 = r_crc;
`else
  logic w_unused;
  assign w_unused = ^{w_crc_en, w_crc_bit,
                      bus.clear_data_crc};
  assign bus.data_crc16 = 16'h0000;
`endif

  assign bus.received_data        = r_rx_data;
  assign bus.mmc_is_in_connecting = (r_state != IDLE);
  assign bus.sent_data_interrupt  =
    r_sent & ~bus.mask_data_interrupt;
  assign bus.received_data_interrupt =
    r_recv & ~bus.mask_data_interrupt;
  assign bus.start_bit_timeout    = r_tmo_flag;
  assign bus.mmc_data_out         = r_out;
  assign bus.mmc_data_oe          = r_oe;

endmodule

// File: tb/tb_kfmmc_data_line.sv
// Randomized bench for kfmmc_data_line against a byte/bit-queue model.
// CRC expectations follow KFMMC_DATA_CRC16_EN.
module tb_kfmmc_data_line;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  kfmmc_data_line_if bus();

  kfmmc_data_line #(.START_TIMEOUT(16'd8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;
  bit q[$];

  // remainder of M(x)*x^16 / (x^16+x^12+x^5+1), long division
  function automatic logic [15:0] crc_of(input bit b[$]);
    bit d[$];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    d = b;
    repeat (16) d.push_back(1'b0);
    for (int i = 0; i + 16 < d.size(); i++)
      if (d[i])
        for (int k = 0; k <= 16; k++)
          d[i+k] = d[i+k] ^ g[16-k];
    for (int k = 0; k < 16; k++)
      r[15-k] = d[d.size()-16+k];
    return r;
  endfunction

  function automatic logic [15:0] exp_crc();
`ifdef KFMMC_DATA_CRC16_EN
    return crc_of(q);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input bit smp, input bit shf);
    bus.mmc_sample_edge = smp;
    bus.mmc_shift_edge  = shf;
    tick();
    bus.mmc_sample_edge = 1'b0;
    bus.mmc_shift_edge  = 1'b0;
  endtask

  task automatic start_xfer(input bit io, input bit chk,
                            input bit cont, input bit clr,
                            input logic [7:0] d);
    bus.start_communication  = 1'b1;
    bus.data_io              = io;
    bus.check_data_start_bit = chk;
    bus.read_continuous_data = cont;
    bus.clear_data_crc       = clr;
    bus.clear_data_interrupt = 1'b1;
    bus.set_send_data        = !io;
    bus.send_data            = d;
    tick();
    bus.start_communication  = 1'b0;
    bus.clear_data_crc       = 1'b0;
    bus.clear_data_interrupt = 1'b0;
    bus.set_send_data        = 1'b0;
    if (clr) q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vecs++;
    if ({bus.received_data, bus.mmc_is_in_connecting,
         bus.sent_data_interrupt,
         bus.received_data_interrupt,
         bus.start_bit_timeout, bus.mmc_data_out,
         bus.mmc_data_oe} !== 14'b0000_0000_0000_10) begin
      errs++;
      $display("FAIL reset_outs: got rx=%h c=%b s=%b r=%b t=%b o=%b oe=%b want 00/0/0/0/0/1/0",
        bus.received_data, bus.mmc_is_in_connecting,
        bus.sent_data_interrupt,
        bus.received_data_interrupt,
        bus.start_bit_timeout, bus.mmc_data_out,
        bus.mmc_data_oe);
    end
    vecs++;
    if (bus.data_crc16 !== 16'h0000) begin
      errs++;
      $display("FAIL reset_crc: got %h want 0000",
        bus.data_crc16);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [7:0] d;
    bit comb;
    for (int n = 0; n < 6; n++) begin
      d = (n == 0) ? 8'hA5 : 8'($urandom);
      comb = (n >= 3);
      start_xfer(1'b0, 1'b0, 1'b0, (n == 0), d);
      vecs++;
      if ({bus.mmc_is_in_connecting, bus.mmc_data_oe,
           bus.mmc_data_out} !== 3'b101) begin
        errs++;
        $display("FAIL wr_start: got c/oe/o=%b%b%b want 101",
          bus.mmc_is_in_connecting, bus.mmc_data_oe,
          bus.mmc_data_out);
      end
      for (int i = 7; i >= 0; i--) begin
        if (comb && i != 7) begin
          strobe(1'b1, 1'b1);
          q.push_back(d[i+1]);
        end else begin
          strobe(1'b0, 1'b1);
        end
        vecs++;
        if ({bus.mmc_data_oe, bus.mmc_data_out}
            !== {1'b1, d[i]}) begin
          errs++;
          $display("FAIL wr_bit%0d: got oe/o=%b%b want 1%b (byte %h)",
            i, bus.mmc_data_oe, bus.mmc_data_out, d[i], d);
        end
        if (!comb) begin
          strobe(1'b1, 1'b0);
          q.push_back(d[i]);
        end
      end
      if (comb) begin
        strobe(1'b1, 1'b0);
        q.push_back(d[0]);
      end
      vecs++;
      if ({bus.sent_data_interrupt,
           bus.mmc_is_in_connecting, bus.mmc_data_oe,
           bus.mmc_data_out} !== 4'b1001) begin
        errs++;
        $display("FAIL wr_done: got irq/c/oe/o=%b%b%b%b want 1001",
          bus.sent_data_interrupt,
          bus.mmc_is_in_connecting, bus.mmc_data_oe,
          bus.mmc_data_out);
      end
      vecs++;
      if (bus.data_crc16 !== exp_crc()) begin
        errs++;
        $display("FAIL wr_crc: got %h want %h",
          bus.data_crc16, exp_crc());
      end
    end
  endtask

  task automatic test_timeout();
    start_xfer(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    bus.mmc_data_in = 1'b1;
    repeat (7) strobe(1'b1, 1'b0);
    vecs++;
    if ({bus.mmc_is_in_connecting,
         bus.received_data_interrupt} !== 2'b10) begin
      errs++;
      $display("FAIL tmo_early: got c/irq=%b%b want 10",
        bus.mmc_is_in_connecting,
        bus.received_data_interrupt);
    end
    strobe(1'b1, 1'b0);
    vecs++;
    if ({bus.received_data, bus.start_bit_timeout,
         bus.received_data_interrupt,
         bus.mmc_is_in_connecting} !== 11'h7FE) begin
      errs++;
      $display("FAIL tmo_done: got rx=%h t=%b irq=%b c=%b want ff/1/1/0",
        bus.received_data, bus.start_bit_timeout,
        bus.received_data_interrupt,
        bus.mmc_is_in_connecting);
    end
  endtask

  task automatic test_read_start_bit();
    logic [10:0] pat;
    pat = {3'b110, 8'h3C};
    start_xfer(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 10; i >= 0; i--) begin
      bus.mmc_data_in = pat[i];
      strobe(1'b1, 1'b0);
      if (i < 8) q.push_back(pat[i]);
      if (i == 9) begin
        vecs++;
        if (bus.mmc_is_in_connecting !== 1'b1) begin
          errs++;
          $display("FAIL rd_wait: got c=%b want 1",
            bus.mmc_is_in_connecting);
        end
      end
    end
    vecs++;
    if ({bus.received_data, bus.received_data_interrupt,
         bus.start_bit_timeout,
         bus.mmc_is_in_connecting} !== {8'h3C, 3'b100}) begin
      errs++;
      $display("FAIL rd_start: got rx=%h irq=%b t=%b c=%b want 3c/1/0/0",
        bus.received_data, bus.received_data_interrupt,
        bus.start_bit_timeout, bus.mmc_is_in_connecting);
    end
    vecs++;
    if (bus.data_crc16 !== exp_crc()) begin
      errs++;
      $display("FAIL rd_start_crc: got %h want %h",
        bus.data_crc16, exp_crc());
    end
  endtask

  task automatic test_read_random();
    logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      start_xfer(1'b1, 1'b0, 1'b1, (n == 0), 8'h00);
      for (int i = 7; i >= 0; i--) begin
        bus.mmc_data_in = d[i];
        strobe(1'b1, 1'b0);
        q.push_back(d[i]);
      end
      vecs++;
      if ({bus.received_data, bus.received_data_interrupt}
          !== {d, 1'b1}) begin
        errs++;
        $display("FAIL rd_rand: got rx=%h irq=%b want %h/1",
          bus.received_data, bus.received_data_interrupt, d);
      end
      vecs++;
      if (bus.data_crc16 !== exp_crc()) begin
        errs++;
        $display("FAIL rd_rand_crc: got %h want %h",
          bus.data_crc16, exp_crc());
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] d;
    d = 8'($urandom);
    start_xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 7; i >= 0; i--) begin
      bus.mmc_data_in = d[i];
      strobe(1'b1, 1'b0);
      q.push_back(d[i]);
      if (i == 5) begin
        bus.start_communication = 1'b1;
        bus.data_io             = 1'b0;
        bus.set_send_data       = 1'b1;
        tick();
        bus.start_communication = 1'b0;
        bus.set_send_data       = 1'b0;
        vecs++;
        if ({bus.mmc_is_in_connecting, bus.mmc_data_oe}
            !== 2'b10) begin
          errs++;
          $display("FAIL ign_start: got c/oe=%b%b want 10",
            bus.mmc_is_in_connecting, bus.mmc_data_oe);
        end
      end
    end
    vecs++;
    if (bus.received_data !== d) begin
      errs++;
      $display("FAIL ign_rx: got %h want %h",
        bus.received_data, d);
    end
  endtask

  task automatic test_crc_512();
    for (int n = 0; n < 512; n++) begin
      start_xfer(1'b1, 1'b0, 1'b1, (n == 0), 8'h00);
      bus.mmc_data_in = 1'b1;
      repeat (8) strobe(1'b1, 1'b0);
    end
    vecs++;
`ifdef KFMMC_DATA_CRC16_EN
    if (bus.data_crc16 !== 16'h7FA1) begin
      errs++;
      $display("FAIL crc512: got %h want 7fa1",
        bus.data_crc16);
    end
`else
    if (bus.data_crc16 !== 16'h0000) begin
      errs++;
      $display("FAIL crc512: got %h want 0000",
        bus.data_crc16);
    end
`endif
    q.delete();
  endtask

  task automatic test_mask();
    logic [7:0] d;
    d = 8'($urandom);
    bus.mask_data_interrupt = 1'b1;
    start_xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 7; i >= 0; i--) begin
      bus.mmc_data_in = d[i];
      strobe(1'b1, 1'b0);
    end
    vecs++;
    if ({bus.received_data_interrupt, bus.received_data}
        !== {1'b0, d}) begin
      errs++;
      $display("FAIL mask_on: got irq=%b rx=%h want 0/%h",
        bus.received_data_interrupt, bus.received_data, d);
    end
    bus.mask_data_interrupt = 1'b0;
    #1;
    vecs++;
    if (bus.received_data_interrupt !== 1'b1) begin
      errs++;
      $display("FAIL mask_off: got irq=%b want 1",
        bus.received_data_interrupt);
    end
    bus.clear_data_interrupt = 1'b1;
    tick();
    bus.clear_data_interrupt = 1'b0;
    vecs++;
    if (bus.received_data_interrupt !== 1'b0) begin
      errs++;
      $display("FAIL mask_clr: got irq=%b want 0",
        bus.received_data_interrupt);
    end
  endtask

  task automatic test_set_wins();
    start_xfer(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    bus.mmc_data_in = 1'b0;
    repeat (7) strobe(1'b1, 1'b0);
    bus.clear_data_interrupt = 1'b1;
    strobe(1'b1, 1'b0);
    bus.clear_data_interrupt = 1'b0;
    vecs++;
    if (bus.received_data_interrupt !== 1'b1) begin
      errs++;
      $display("FAIL set_wins: got irq=%b want 1",
        bus.received_data_interrupt);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    d = 8'($urandom);
    start_xfer(1'b0, 1'b0, 1'b0, 1'b1, d);
    repeat (3) begin
      strobe(1'b0, 1'b1);
      strobe(1'b1, 1'b0);
    end
    reset = 1'b1;
    #1;
    vecs++;
    if ({bus.received_data, bus.mmc_is_in_connecting,
         bus.sent_data_interrupt,
         bus.received_data_interrupt,
         bus.start_bit_timeout, bus.mmc_data_out,
         bus.mmc_data_oe, bus.data_crc16}
        !== {14'b0000_0000_0000_10, 16'h0000}) begin
      errs++;
      $display("FAIL mid_reset: got rx=%h c=%b s=%b r=%b t=%b o=%b oe=%b crc=%h",
        bus.received_data, bus.mmc_is_in_connecting,
        bus.sent_data_interrupt,
        bus.received_data_interrupt,
        bus.start_bit_timeout, bus.mmc_data_out,
        bus.mmc_data_oe, bus.data_crc16);
    end
    tick();
    reset = 1'b0;
    tick();
    q.delete();
    d = 8'($urandom);
    start_xfer(1'b0, 1'b0, 1'b0, 1'b0, d);
    for (int i = 7; i >= 0; i--) begin
      strobe(1'b0, 1'b1);
      vecs++;
      if ({bus.mmc_data_oe, bus.mmc_data_out}
          !== {1'b1, d[i]}) begin
        errs++;
        $display("FAIL post_rst_bit%0d: got oe/o=%b%b want 1%b",
          i, bus.mmc_data_oe, bus.mmc_data_out, d[i]);
      end
      strobe(1'b1, 1'b0);
      q.push_back(d[i]);
    end
    vecs++;
    if ({bus.sent_data_interrupt,
         bus.mmc_is_in_connecting, bus.mmc_data_oe,
         bus.data_crc16} !== {3'b100, exp_crc()}) begin
      errs++;
      $display("FAIL post_rst_done: got irq/c/oe=%b%b%b crc=%h want 100 %h",
        bus.sent_data_interrupt,
        bus.mmc_is_in_connecting, bus.mmc_data_oe,
        bus.data_crc16, exp_crc());
    end
  endtask

  initial begin
    bus.mmc_sample_edge      = 1'b0;
    bus.mmc_shift_edge       = 1'b0;
    bus.start_communication  = 1'b0;
    bus.data_io              = 1'b0;
    bus.check_data_start_bit = 1'b0;
    bus.read_continuous_data = 1'b0;
    bus.clear_data_crc       = 1'b0;
    bus.clear_data_interrupt = 1'b0;
    bus.mask_data_interrupt  = 1'b0;
    bus.set_send_data        = 1'b0;
    bus.send_data            = 8'h00;
    bus.mmc_data_in          = 1'b1;
    test_reset();
    test_write();
    test_timeout();
    test_read_start_bit();
    test_read_random();
    test_ignore_start();
    test_crc_512();
    test_mask();
    test_set_wins();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==",
      vecs, errs);
    $finish;
  end

endmodule
